// File: rtl/pkt_wr_pkg.sv
// rtl/pkt_wr_pkg.sv - shared types and widths for the packet copy buffer write side
package pkt_wr_pkg;

  localparam int DEPTH_DEF   = 3072;
  localparam int MAX_LEN_DEF = 1518;
  localparam int AW          = $clog2(DEPTH_DEF);
  localparam int LW          = $clog2(MAX_LEN_DEF + 1);
  localparam int OW          = $clog2(DEPTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DROP
  } state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } desc_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/desc_fifo.sv
// rtl/desc_fifo.sv - shift-register descriptor FIFO; head entry is the registered output
module desc_fifo
  import pkt_wr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  desc_t                      i_desc,
  input  logic                       i_pop,
  output desc_t                      o_desc,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  desc_t          mem [DEPTH];
  logic           pop;
  logic           push_ok;
  logic [CW-1:0]  count_next;
  logic [IW-1:0]  wr_idx;

  always_comb begin
    pop        = i_pop & o_valid;
    push_ok    = i_push & (~o_full | pop);
    count_next = o_count + CW'(push_ok) - CW'(pop);
    // a simultaneous pop shifts everything down, so the new entry lands one slot lower
    wr_idx     = pop ? IW'(o_count - 1'b1) : IW'(o_count);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      o_count <= '0;
      o_valid <= 1'b0;
      o_full  <= 1'b0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (push_ok) mem[wr_idx] <= i_desc;
      o_count <= count_next;
      o_valid <= (count_next != '0);
      o_full  <= (count_next == CW'(DEPTH));
    end
  end

  assign o_desc = mem[0];

endmodule

// File: rtl/pkt_wr_ctrl.sv
// rtl/pkt_wr_ctrl.sv - packet ingress writer: admission, contiguous SRAM writes, occupancy, descriptors
module pkt_wr_ctrl
  import pkt_wr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int DESC_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_sop,
  input  logic                  i_eop,
  output logic [AW-1:0]         o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_desc_valid,
  input  logic                  i_desc_ready,
  output logic [AW-1:0]         o_desc_addr,
  output logic [LW-1:0]         o_desc_len,
  input  logic                  i_release,
  input  logic [LW-1:0]         i_release_len,
  output logic [15:0]           o_drop_cnt
);

  localparam int            CW        = $clog2(DESC_DEPTH + 1);
  localparam logic [OW-1:0] OCC_LIMIT = OW'(DEPTH - MAX_LEN);

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] pkt_start;
  logic [LW:0]   pkt_len;
  logic [OW-1:0] occ;
  logic          push_pend;
  desc_t         push_desc;

  desc_t         fifo_desc;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;

  logic          sop_v;
  logic          byte_v;
  logic          over;
  logic          admit;
  logic          commit;
  logic [AW-1:0] base;
  logic [AW-1:0] commit_addr;
  logic [LW-1:0] commit_len;
  logic [1:0]    drop_inc;
  logic [OW:0]   occ_sum;
  logic [OW:0]   rel_amt;
  logic [OW-1:0] occ_next;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  always_comb begin
    sop_v  = i_valid & i_sop;
    byte_v = i_valid & ~i_sop & (state == WRITE);
    over   = byte_v & (pkt_len == (LW+1)'(MAX_LEN));
    // the descriptor pushed last cycle has not landed in the FIFO yet, so reserve its slot
    admit  = ~fifo_full & ~(push_pend & (fifo_count == CW'(DESC_DEPTH - 1))) & (occ <= OCC_LIMIT);
    base   = (state == WRITE) ? pkt_start : wr_ptr;

    commit      = (sop_v & admit & i_eop) | (byte_v & ~over & i_eop);
    commit_addr = sop_v ? base : pkt_start;
    commit_len  = sop_v ? LW'(1) : LW'(pkt_len + 1'b1);

    drop_inc = 2'(sop_v & (state == WRITE)) + 2'(sop_v & ~admit) + 2'(over);

    occ_sum  = {1'b0, occ} + (commit ? (OW+1)'(commit_len) : '0);
    rel_amt  = i_release ? (OW+1)'(i_release_len) : '0;
    occ_next = (rel_amt > occ_sum) ? '0 : OW'(occ_sum - rel_amt);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      pkt_start   <= '0;
      pkt_len     <= '0;
      occ         <= '0;
      push_pend   <= 1'b0;
      push_desc   <= '0;
      o_mem_addr  <= '0;
      o_mem_write <= 1'b0;
      o_mem_data  <= '0;
      o_drop_cnt  <= '0;
    end else begin
      o_mem_write <= 1'b0;
      occ         <= occ_next;
      o_drop_cnt  <= sat_add16(o_drop_cnt, drop_inc);
      push_pend   <= commit;
      push_desc   <= '{addr: commit_addr, len: commit_len};

      if (sop_v) begin
        if (admit) begin
          o_mem_write <= 1'b1;
          o_mem_addr  <= base;
          o_mem_data  <= i_data;
          wr_ptr      <= next_addr(base);
          pkt_start   <= base;
          pkt_len     <= (LW+1)'(1);
          state       <= i_eop ? IDLE : WRITE;
        end else begin
          wr_ptr <= base;
          state  <= i_eop ? IDLE : DROP;
        end
      end else if (byte_v) begin
        if (over) begin
          wr_ptr <= pkt_start;
          state  <= i_eop ? IDLE : DROP;
        end else begin
          o_mem_write <= 1'b1;
          o_mem_addr  <= wr_ptr;
          o_mem_data  <= i_data;
          wr_ptr      <= next_addr(wr_ptr);
          pkt_len     <= pkt_len + 1'b1;
          if (i_eop) state <= IDLE;
        end
      end else if (i_valid & i_eop & (state == DROP)) begin
        state <= IDLE;
      end
    end
  end

  desc_fifo #(
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_pend),
    .i_desc  (push_desc),
    .i_pop   (i_desc_ready),
    .o_desc  (fifo_desc),
    .o_valid (o_desc_valid),
    .o_full  (fifo_full),
    .o_count (fifo_count)
  );

  assign o_desc_addr = fifo_desc.addr;
  assign o_desc_len  = fifo_desc.len;

endmodule

// File: tb/tb_pkt_wr_ctrl.sv
// tb/tb_pkt_wr_ctrl.sv - directed self-checking bench for pkt_wr_ctrl
module tb_pkt_wr_ctrl;
  import pkt_wr_pkg::*;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [7:0]    i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_sop = 1'b0;
  logic          i_eop = 1'b0;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_write;
  logic [7:0]    o_mem_data;
  logic          o_desc_valid;
  logic          i_desc_ready = 1'b0;
  logic [AW-1:0] o_desc_addr;
  logic [LW-1:0] o_desc_len;
  logic          i_release = 1'b0;
  logic [LW-1:0] i_release_len = '0;
  logic [15:0]   o_drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]    mem_model [3072];
  logic [AW-1:0] dq_addr [$];
  logic [LW-1:0] dq_len [$];

  pkt_wr_ctrl dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .i_sop         (i_sop),
    .i_eop         (i_eop),
    .o_mem_addr    (o_mem_addr),
    .o_mem_write   (o_mem_write),
    .o_mem_data    (o_mem_data),
    .o_desc_valid  (o_desc_valid),
    .i_desc_ready  (i_desc_ready),
    .o_desc_addr   (o_desc_addr),
    .o_desc_len    (o_desc_len),
    .i_release     (i_release),
    .i_release_len (i_release_len),
    .o_drop_cnt    (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  // inputs only change just after posedge, so the negedge view matches what the next edge consumes
  always @(negedge i_clk) begin
    if (!i_rst && o_mem_write) mem_model[o_mem_addr] <= o_mem_data;
    if (!i_rst && o_desc_valid && i_desc_ready) begin
      dq_addr.push_back(o_desc_addr);
      dq_len.push_back(o_desc_len);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop);
    i_valid = 1'b1; i_data = d; i_sop = sop; i_eop = eop;
    tick();
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [7:0] seed);
    for (int i = 0; i < len; i++) send_byte(seed + 8'(i), i == 0, i == len - 1);
  endtask

  task automatic release_bytes(input int len);
    i_release = 1'b1; i_release_len = LW'(len);
    tick();
    i_release = 1'b0; i_release_len = '0;
  endtask

  task automatic do_reset();
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_release = 1'b0; i_desc_ready = 1'b0;
    i_rst = 1'b1;
    idle(2);
    i_rst = 1'b0;
    dq_addr.delete();
    dq_len.delete();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    idle(2);
    checks++; if (o_mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %0b want 0", o_mem_write); end
    checks++; if (o_mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %0d want 0", o_mem_addr); end
    checks++; if (o_mem_data !== '0) begin errors++; $display("FAIL reset_mem_data got %0h want 0", o_mem_data); end
    checks++; if (o_desc_valid !== 1'b0) begin errors++; $display("FAIL reset_desc_valid got %0b want 0", o_desc_valid); end
    checks++; if (o_desc_addr !== '0 || o_desc_len !== '0) begin errors++; $display("FAIL reset_desc got {%0d,%0d} want {0,0}", o_desc_addr, o_desc_len); end
    checks++; if (o_drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", o_drop_cnt); end
    i_rst = 1'b0;
  endtask

  task automatic test_single();
    int bad;
    do_reset();
    send_pkt(64, 8'h01);
    checks++; if (o_mem_write !== 1'b1 || o_mem_addr !== 12'd63 || o_mem_data !== 8'h40) begin
      errors++; $display("FAIL single_last_write got we=%0b a=%0d d=%0h want we=1 a=63 d=40", o_mem_write, o_mem_addr, o_mem_data); end
    checks++; if (o_desc_valid !== 1'b0) begin errors++; $display("FAIL single_desc_early got %0b want 0", o_desc_valid); end
    tick();
    checks++; if (o_desc_valid !== 1'b1 || o_desc_addr !== 12'd0 || o_desc_len !== 11'd64) begin
      errors++; $display("FAIL single_desc got v=%0b {%0d,%0d} want v=1 {0,64}", o_desc_valid, o_desc_addr, o_desc_len); end
    checks++; if (dut.occ !== 12'd64) begin errors++; $display("FAIL single_occ got %0d want 64", dut.occ); end
    checks++; if (o_drop_cnt !== 16'd0) begin errors++; $display("FAIL single_drop got %0d want 0", o_drop_cnt); end
    i_desc_ready = 1'b1;
    idle(3);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem_model[i] !== 8'(i + 1)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL single_sram got %0d bad bytes want 0", bad); end
    checks++; if (dq_addr.size() != 1 || o_desc_valid !== 1'b0) begin
      errors++; $display("FAIL single_desc_count got %0d valid=%0b want 1 valid=0", dq_addr.size(), o_desc_valid); end
  endtask

  task automatic test_wrap();
    int bad;
    do_reset();
    i_desc_ready = 1'b1;
    send_pkt(1518, 8'h00); idle(3); release_bytes(1518);
    send_pkt(1518, 8'h00); idle(3); release_bytes(1518);
    send_pkt(4, 8'h00);    idle(3); release_bytes(4);
    dq_addr.delete(); dq_len.delete();
    send_pkt(64, 8'h80);
    idle(4);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem_model[(3040 + i) % 3072] !== 8'(8'h80 + i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_sram got %0d bad bytes want 0", bad); end
    checks++; if (dq_addr.size() != 1 || dq_addr[0] !== 12'd3040 || dq_len[0] !== 11'd64) begin
      errors++; $display("FAIL wrap_desc got n=%0d {%0d,%0d} want n=1 {3040,64}", dq_addr.size(), dq_addr[0], dq_len[0]); end
    release_bytes(64);
    dq_addr.delete(); dq_len.delete();
    send_byte(8'h55, 1'b1, 1'b1);
    idle(4);
    checks++; if (dq_addr.size() != 1 || dq_addr[0] !== 12'd32 || dq_len[0] !== 11'd1) begin
      errors++; $display("FAIL wrap_next_ptr got n=%0d {%0d,%0d} want n=1 {32,1}", dq_addr.size(), dq_addr[0], dq_len[0]); end
    checks++; if (dut.occ !== 12'd1) begin errors++; $display("FAIL wrap_occ got %0d want 1", dut.occ); end
  endtask

  task automatic test_oversize();
    do_reset();
    i_desc_ready = 1'b1;
    send_pkt(1519, 8'h00);
    send_pkt(10, 8'h30);
    idle(4);
    checks++; if (o_drop_cnt !== 16'd1) begin errors++; $display("FAIL oversize_drop got %0d want 1", o_drop_cnt); end
    checks++; if (dq_addr.size() != 1 || dq_addr[0] !== 12'd0 || dq_len[0] !== 11'd10) begin
      errors++; $display("FAIL oversize_desc got n=%0d {%0d,%0d} want n=1 {0,10}", dq_addr.size(), dq_addr[0], dq_len[0]); end
    checks++; if (mem_model[0] !== 8'h30 || mem_model[9] !== 8'h39) begin
      errors++; $display("FAIL oversize_sram got %0h,%0h want 30,39", mem_model[0], mem_model[9]); end
    checks++; if (dut.occ !== 12'd10) begin errors++; $display("FAIL oversize_occ got %0d want 10", dut.occ); end
  endtask

  task automatic test_space();
    do_reset();
    i_desc_ready = 1'b1;
    send_pkt(1518, 8'h00);
    send_pkt(82, 8'h00);
    idle(3);
    checks++; if (dut.occ !== 12'd1600) begin errors++; $display("FAIL space_occ_pre got %0d want 1600", dut.occ); end
    dq_addr.delete(); dq_len.delete();
    i_valid = 1'b1; i_sop = 1'b1; i_eop = 1'b0; i_data = 8'hAA;
    i_release = 1'b1; i_release_len = 11'd64;
    tick();
    i_valid = 1'b0; i_sop = 1'b0; i_release = 1'b0; i_release_len = '0;
    send_byte(8'hBB, 1'b1, 1'b1);
    idle(4);
    checks++; if (o_drop_cnt !== 16'd1) begin errors++; $display("FAIL space_drop got %0d want 1", o_drop_cnt); end
    checks++; if (dq_addr.size() != 1 || dq_addr[0] !== 12'd1600 || dq_len[0] !== 11'd1) begin
      errors++; $display("FAIL space_desc got n=%0d {%0d,%0d} want n=1 {1600,1}", dq_addr.size(), dq_addr[0], dq_len[0]); end
    checks++; if (dut.occ !== 12'd1537) begin errors++; $display("FAIL space_occ got %0d want 1537", dut.occ); end
    checks++; if (mem_model[1600] !== 8'hBB) begin errors++; $display("FAIL space_sram got %0h want bb", mem_model[1600]); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int k = 0; k < 5; k++) send_pkt(20, 8'(k * 20));
    idle(3);
    checks++; if (o_drop_cnt !== 16'd1) begin errors++; $display("FAIL fifo_full_drop got %0d want 1", o_drop_cnt); end
    checks++; if (o_desc_valid !== 1'b1 || o_desc_addr !== 12'd0 || o_desc_len !== 11'd20) begin
      errors++; $display("FAIL fifo_full_hold got v=%0b {%0d,%0d} want v=1 {0,20}", o_desc_valid, o_desc_addr, o_desc_len); end
    i_desc_ready = 1'b1;
    idle(6);
    checks++; if (dq_addr.size() != 4) begin errors++; $display("FAIL fifo_full_count got %0d want 4", dq_addr.size()); end
    for (int k = 0; k < 4 && k < dq_addr.size(); k++) begin
      checks++; if (dq_addr[k] !== 12'(20 * k) || dq_len[k] !== 11'd20) begin
        errors++; $display("FAIL fifo_full_order[%0d] got {%0d,%0d} want {%0d,20}", k, dq_addr[k], dq_len[k], 20 * k); end
    end
  endtask

  task automatic test_abort();
    do_reset();
    i_desc_ready = 1'b1;
    for (int i = 0; i < 30; i++) send_byte(8'(i), i == 0, 1'b0);
    send_pkt(10, 8'h60);
    idle(4);
    checks++; if (o_drop_cnt !== 16'd1) begin errors++; $display("FAIL abort_drop got %0d want 1", o_drop_cnt); end
    checks++; if (dq_addr.size() != 1 || dq_addr[0] !== 12'd0 || dq_len[0] !== 11'd10) begin
      errors++; $display("FAIL abort_desc got n=%0d {%0d,%0d} want n=1 {0,10}", dq_addr.size(), dq_addr[0], dq_len[0]); end
    checks++; if (mem_model[0] !== 8'h60 || mem_model[9] !== 8'h69) begin
      errors++; $display("FAIL abort_sram got %0h,%0h want 60,69", mem_model[0], mem_model[9]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_desc_ready = 1'b1;
    for (int i = 0; i < 20; i++) send_byte(8'(i), i == 0, 1'b0);
    i_valid = 1'b1; i_data = 8'hEE;
    #2;
    i_rst = 1'b1;
    #1;
    checks++; if (o_mem_write !== 1'b0 || o_mem_addr !== '0 || o_mem_data !== '0) begin
      errors++; $display("FAIL midrst_mem got we=%0b a=%0d d=%0h want 0", o_mem_write, o_mem_addr, o_mem_data); end
    checks++; if (o_desc_valid !== 1'b0 || o_drop_cnt !== 16'd0) begin
      errors++; $display("FAIL midrst_desc got v=%0b drop=%0d want 0", o_desc_valid, o_drop_cnt); end
    tick();
    i_valid = 1'b0;
    i_rst = 1'b0;
    idle(4);
    checks++; if (dq_addr.size() != 0 || dut.occ !== 12'd0) begin
      errors++; $display("FAIL midrst_state got n=%0d occ=%0d want 0,0", dq_addr.size(), dut.occ); end
    send_pkt(5, 8'h70);
    idle(4);
    checks++; if (dq_addr.size() != 1 || dq_addr[0] !== 12'd0 || dq_len[0] !== 11'd5) begin
      errors++; $display("FAIL midrst_after got n=%0d {%0d,%0d} want n=1 {0,5}", dq_addr.size(), dq_addr[0], dq_len[0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_oversize();
    test_space();
    test_fifo_full();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
